// File: rtl/InsnDecodePkg.sv
// Shared decode types: the 32-bit opcode type and the NOP classifier.
//   InsnOpcode  : raw 32-bit instruction word
//   insn_is_NOP : 1 when op[31:23]==0, op[7:2]==0 and op[0]==1
package InsnDecodePkg;

    typedef logic [31:0] InsnOpcode;

    // Bits that must match for a NOP, and the value they must hold.
    localparam InsnOpcode NOP_MASK  = 32'hFF80_00FD;
    localparam InsnOpcode NOP_MATCH = 32'h0000_0001;

    function automatic logic insn_is_NOP(input InsnOpcode op);
        return (op & NOP_MASK) == NOP_MATCH;
    endfunction

endpackage

// File: rtl/insn_fetch_queue_pkg.sv
// Local constants for the fetch queue.
//   INSN_WIDTH : width of a stored opcode, taken from InsnOpcode
package insn_fetch_queue_pkg;

    import InsnDecodePkg::*;

    localparam int unsigned INSN_WIDTH = $bits(InsnOpcode);

endpackage

// File: rtl/insn_fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write entry
//   raddr : read index
//   rdata : entry at raddr (combinational)
module insn_fetch_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Async read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/insn_fetch_queue.sv
// Instruction fetch queue: circular FIFO between fetch and decode.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : discard all entries (priority over handshakes)
//   enq_valid/ready     : fetch handshake; enq_ready = not full
//   enq_insn, enq_pc    : fetched opcode and its address
//   deq_valid/ready     : decode handshake; deq_valid = not empty
//   deq_insn, deq_pc    : head entry, zero when deq_valid is low
//   count               : current occupancy
// Build option: INSN_FETCH_QUEUE_NOP_SQUASH_EN drops NOP opcodes at enqueue
// (handshake completes, nothing is stored).
module insn_fetch_queue
    import InsnDecodePkg::*;
    import insn_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  InsnOpcode              enq_insn,
    input  logic [PC_WIDTH-1:0]    enq_pc,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output InsnOpcode              deq_insn,
    output logic [PC_WIDTH-1:0]    deq_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = INSN_WIDTH + PC_WIDTH;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;
    logic          enq_keep;
    logic          wr_en;
    logic [EW-1:0] rd_data;

    // Status flags decoded from the occupancy register
    assign enq_ready = (count != CW'(DEPTH));
    assign deq_valid = (count != CW'(0));

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

`ifdef INSN_FETCH_QUEUE_NOP_SQUASH_EN
    assign enq_keep = ~insn_is_NOP(enq_insn);
`else
    assign enq_keep = 1'b1;
`endif

    // A squashed NOP completes its handshake but takes no slot
    assign wr_en = enq_fire & enq_keep & ~flush;

    // Pointers and occupancy; flush overrides any same-cycle handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(deq_fire);
        end
    end

    insn_fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({enq_insn, enq_pc}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Head entry, masked to zero while empty
    assign deq_insn = deq_valid ? rd_data[EW-1 -: INSN_WIDTH] : '0;
    assign deq_pc   = deq_valid ? rd_data[PC_WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Self-checking bench for insn_fetch_queue: directed stimulus pushes the
// expected entries into a scoreboard; a negedge monitor pops and compares
// every dequeue. Works with or without INSN_FETCH_QUEUE_NOP_SQUASH_EN.
module tb_insn_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PCW   = 32;
`ifdef INSN_FETCH_QUEUE_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            enq_valid;
    logic            enq_ready;
    logic [31:0]     enq_insn;
    logic [PCW-1:0]  enq_pc;
    logic            deq_valid;
    logic            deq_ready;
    logic [31:0]     deq_insn;
    logic [PCW-1:0]  deq_pc;
    logic [2:0]      count;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    int   mcnt   = 0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    insn_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_insn  (enq_insn),
        .enq_pc    (enq_pc),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_insn  (deq_insn),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    function automatic bit bench_nop(input logic [31:0] op);
        return (op[31:23] == 9'd0) && (op[7:2] == 6'd0) && op[0];
    endfunction

    // One cycle of stimulus, entered and left at posedge+1
    task automatic step(input bit ev, input logic [31:0] insn, input logic [31:0] pc,
                        input bit dr, input bit fl);
        bit acc;
        bit deq;
        acc = ev && (mcnt < int'(DEPTH)) && !fl && !(SQUASH && bench_nop(insn));
        deq = dr && (mcnt > 0) && !fl;
        enq_valid = ev;
        enq_insn  = insn;
        enq_pc    = pc;
        deq_ready = dr;
        flush     = fl;
        #1;
        check("count", 64'(count), 64'(mcnt));
        check("enq_ready", 64'(enq_ready), 64'(mcnt != int'(DEPTH)));
        check("deq_valid", 64'(deq_valid), 64'(mcnt != 0));
        if (acc) exp_q.push_back('{insn, pc});
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            mcnt = mcnt + int'(acc) - int'(deq);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        while (mcnt > 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    // Scoreboard monitor: compares each dequeued head against the model
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            if (!deq_valid) begin
                check("idle_zero", {deq_insn, deq_pc}, 64'h0);
            end else if (!flush && deq_ready) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", 64'(deq_pc), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("deq_insn", 64'(deq_insn), 64'(e.insn));
                    check("deq_pc", 64'(deq_pc), 64'(e.pc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_insn = '0; enq_pc = '0;
        #1;
        check("rst_count", 64'(count), 64'h0);
        check("rst_enq_ready", 64'(enq_ready), 64'h1);
        check("rst_deq", {deq_valid, deq_insn, deq_pc[30:0]}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full with decode stalled; a fifth offer is refused
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1000_0001 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h1000_00FF, 32'h1FC, 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'h4);
        check("fill_enq_ready", 64'(enq_ready), 64'h0);
        check("fill_deq_pc", 64'(deq_pc), 64'h100);

        // Drain across the wrap with two enqueues mid-stream
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h1000_0005, 32'h110, 1'b1, 1'b0);
        step(1'b1, 32'h1000_0006, 32'h114, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain_count", 64'(count), 64'h0);

        // Concurrent enqueue and dequeue at count 2
        step(1'b1, 32'h2000_0000, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h2000_0004, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'h2000_0008, 32'h208, 1'b1, 1'b0);
        check("conc_count", 64'(count), 64'h2);
        check("conc_deq_pc", 64'(deq_pc), 64'h204);
        drain();

        // Flush at count 3 with same-cycle handshakes
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, 32'h3000_0003, 32'h30C, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'h0);
        check("flush_deq_valid", 64'(deq_valid), 64'h0);
        check("flush_enq_ready", 64'(enq_ready), 64'h1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush_lost", 64'(count), 64'h0);

        // NOP handling
        step(1'b1, 32'h0000_0001, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h0000_000D, 32'h404, 1'b0, 1'b0);
        check("nop_count", 64'(count), SQUASH ? 64'h1 : 64'h2);
        check("nop_head", 64'(deq_insn), SQUASH ? 64'hD : 64'h1);
        drain();

        // Reset mid-run with an enqueue in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h4000_0000 + 32'(i), 32'h480 + 32'(4 * i), 1'b0, 1'b0);
        enq_valid = 1'b1; enq_insn = 32'h4000_00AA; enq_pc = 32'h4AA;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 64'(count), 64'h0);
        check("mid_rst_enq_ready", 64'(enq_ready), 64'h1);
        check("mid_rst_deq", {deq_valid, deq_insn, deq_pc[30:0]}, 64'h0);
        exp_q.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq_valid = 1'b0;
        step(1'b1, 32'h5000_0000, 32'h500, 1'b0, 1'b0);
        check("post_rst_valid", 64'(deq_valid), 64'h1);
        check("post_rst_pc", 64'(deq_pc), 64'h500);
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/insn_fetch_queue.md
INSN_FETCH_QUEUE -- requirements
Module: insn_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries (power of two, >=2).
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the instruction address.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all entries (redirect from branch/exception).
REQ-006 SHALL have port enq_valid  input  1  fetch presents an instruction.
REQ-007 SHALL have port enq_ready  output  1  queue accepts; equals "not full".
REQ-008 SHALL have port enq_insn  input  32  fetched opcode (InsnOpcode).
REQ-009 SHALL have port enq_pc  input  PC_WIDTH  address of enq_insn.
REQ-010 SHALL have port deq_valid  output  1  decode-side entry available; equals "not empty".
REQ-011 SHALL have port deq_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have port deq_insn  output  32  head opcode.
REQ-013 SHALL have port deq_pc  output  PC_WIDTH  head address.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL be a circular FIFO: write pointer, read pointer, occupancy counter, each log2(DEPTH) bits (counter one wider); pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL enqueue when enq_valid & enq_ready; SHALL dequeue when deq_valid & deq_ready.
REQ-017 SHALL present deq_insn/deq_pc combinationally from the head entry (zero added latency beyond storage); an entry written in cycle N is visible at deq in cycle N+1.
REQ-018 SHALL allow simultaneous enqueue and dequeue when full: enq_ready remains 0 when full (no pass-through), so a full queue only dequeues that cycle.
REQ-019 SHALL, on simultaneous enqueue and dequeue when neither full nor empty, keep count unchanged and advance both pointers.
REQ-020 SHALL NOT bypass enqueue data to deq outputs when empty; deq_valid is 0 in the cycle of the first write.
REQ-021 SHALL drive deq_insn/deq_pc to zero when deq_valid is 0.
REQ-022 SHALL, on flush, set both pointers and count to 0 next cycle, ignoring any same-cycle enqueue and dequeue; flush has priority over all handshakes.
REQ-023 SHALL keep deq_valid=0 and enq_ready=1 in the cycle after flush.
REQ-024 SHALL hold stored entries unchanged while deq_ready is low (back-pressure); deq outputs stable until consumed.

Reset
REQ-025 SHALL, on rst asserted, immediately clear pointers and count; outputs: enq_ready=1, deq_valid=0, deq_insn=0, deq_pc=0, count=0.
REQ-026 SHALL discard any in-flight handshake when rst asserts mid-operation; storage array contents need not be reset.

Configuration
REQ-027 SHALL, with INSN_FETCH_QUEUE_NOP_SQUASH_EN defined, drop NOP opcodes at enqueue (op[31:23]==0, op[7:2]==0, op[0]==1): handshake completes (enq_ready honoured) but no entry is written and count is unchanged.
REQ-028 SHALL, without INSN_FETCH_QUEUE_NOP_SQUASH_EN, store NOPs like any other opcode.

Structure
REQ-029 SHALL take InsnOpcode and insn_is_NOP from InsnDecodePkg; no new package types required.
REQ-030 SHALL keep the entry storage in one sub-module insn_fetch_queue_ram (DEPTH x (32+PC_WIDTH), one write port, one async read port).

Verification
REQ-031 Fill: 4 enqueues (insn 0x1000_0001.. pcs 0x100,0x104,0x108,0x10C), deq_ready=0 -> count=4, enq_ready=0, deq_pc=0x100.
REQ-032 Drain/wrap: from full, 6 cycles deq_ready=1 with 2 new enqueues mid-stream -> pcs dequeued in order 0x100..0x10C,0x110,0x114; pointers wrap; count ends 0.
REQ-033 Concurrent: count=2, enq+deq same cycle -> count stays 2, deq_pc advances by one entry.
REQ-034 Flush: count=3, flush with enq_valid=1 and deq_ready=1 same cycle -> next cycle count=0, deq_valid=0, enqueued insn lost.
REQ-035 NOP squash: enqueue 0x0000_0001 then 0x0000_000D -> with macro count=1 and deq_insn=0x0000_000D; without macro count=2, head 0x0000_0001.
REQ-036 Reset mid-run: rst pulse with count=3 -> outputs immediately at reset values; first enqueue after release appears at deq next cycle.
